// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage engine with one outstanding req/ack read and redirect handling
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds fetch_cnt / drop_cnt outputs)
//
// Ports:
//   clk            in   clock
//   resetn         in   synchronous active-low reset
//   IF_valid       in   IF stage valid from pipeline controller
//   next_fetch     in   controller permits IF to advance (includes cancel)
//   cancel         in   flush/redirect pulse
//   cancel_target  in   redirect PC, truncated to a word boundary
//   inst_req       out  level instruction read request
//   inst_addr      out  word-aligned read address, stable until inst_ack
//   inst_ack       in   response valid, may coincide with the first inst_req cycle
//   inst_rdata     in   instruction word, valid with inst_ack
//   IF_over        out  instruction held and IF stage valid
//   IF_inst        out  held instruction
//   IF_pc          out  PC of held instruction
//   fetch_cnt      out  (FETCH_PERF_CNT_EN) completed sequential advances out of HOLD
//   drop_cnt       out  (FETCH_PERF_CNT_EN) discarded responses plus dropped held instructions
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        IF_valid,
  input  logic        next_fetch,
  input  logic        cancel,
  input  logic [31:0] cancel_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic        IF_over,
  output logic [31:0] IF_inst,
  output logic [31:0] IF_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] drop_cnt
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        pend_q, pend_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] cancel_pc;
  logic        in_req, idle_go, hold_go, ack_ok, ack_drop, req_cancel;
  assign cancel_pc  = cancel_target & ~32'h3;
  assign in_req     = state_q == S_REQ;
  assign idle_go    = (state_q == S_IDLE) & IF_valid;
  assign hold_go    = (state_q == S_HOLD) & next_fetch;
  assign ack_ok     = in_req & inst_ack & ~cancel & ~pend_q;
  // A response that crosses a cancel belongs to the old stream and is thrown away.
  assign ack_drop   = in_req & inst_ack & (cancel | pend_q);
  // Cancel before the response: the request stays on the bus, only the pc moves.
  assign req_cancel = in_req & ~inst_ack & cancel;
  always_comb begin
    pc_d       = ((in_req | hold_go) & cancel) ? cancel_pc : hold_go ? pc_q + PC_STEP : pc_q;
    // The bus address is only reloaded when a new request begins, so a pending redirect
    // never disturbs the address of the request still in flight.
    req_addr_d = idle_go ? pc_q : (ack_drop | hold_go) ? pc_d : req_addr_q;
    pend_d     = req_cancel ? 1'b1 : ack_drop ? 1'b0 : pend_q;
    state_d    = (idle_go | hold_go) ? S_REQ : ack_ok ? S_HOLD : state_q;
    inst_d     = ack_ok ? inst_rdata : inst_q;
    ipc_d      = ack_ok ? pc_q : ipc_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      pend_q     <= 1'b0;
      inst_q     <= '0;
      ipc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      pend_q     <= pend_d;
      inst_q     <= inst_d;
      ipc_q      <= ipc_d;
    end
  end
  assign inst_req  = in_req;
  assign inst_addr = req_addr_q & ~32'h3;
  assign IF_over   = (state_q == S_HOLD) & IF_valid;
  assign IF_inst   = inst_q;
  assign IF_pc     = ipc_q;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, drop_cnt_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + {31'd0, hold_go & ~cancel};
      drop_cnt_q  <= drop_cnt_q + {31'd0, ack_drop | (hold_go & cancel)};
    end
  end
  assign fetch_cnt = fetch_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for if_fetch_unit with a latency-programmable memory model
module tb_if_fetch_unit;
  logic        clk = 0;
  logic        resetn = 0;
  logic        IF_valid = 1;
  logic        next_fetch;
  logic        cancel = 0;
  logic [31:0] cancel_target = 0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        IF_over;
  logic [31:0] IF_inst;
  logic [31:0] IF_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, drop_cnt;
`endif
  logic        nf_tie = 0;
  logic        nf_drv = 0;
  int          lat = 0;
  int          cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic        prev_over = 0;
  logic [63:0] sb[$];
  if_fetch_unit dut (
    .clk(clk), .resetn(resetn), .IF_valid(IF_valid), .next_fetch(next_fetch),
    .cancel(cancel), .cancel_target(cancel_target), .inst_req(inst_req),
    .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
    .IF_over(IF_over), .IF_inst(IF_inst), .IF_pc(IF_pc)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .drop_cnt(drop_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2401_0005 : a ^ 32'hDEAD_0000;
  endfunction
  assign next_fetch = nf_tie ? IF_over : nf_drv;
  assign inst_ack   = inst_req && (cnt == lat);
  assign inst_rdata = mem(inst_addr);
  always @(posedge clk) begin
    if (!resetn) cnt <= 0;
    else if (inst_req) cnt <= inst_ack ? 0 : cnt + 1;
  end
  // Each rising edge of IF_over presents a newly fetched instruction.
  always @(negedge clk) begin
    if (IF_over && !prev_over) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected pc=%h inst=%h with no expected entry", IF_pc, IF_inst);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({IF_pc, IF_inst} !== e) begin
          errors++;
          $display("FAIL sb_data pc=%h inst=%h expected pc=%h inst=%h", IF_pc, IF_inst, e[63:32], e[31:0]);
        end
      end
    end
    prev_over = IF_over;
  end
  task automatic push(input logic [31:0] a);
    sb.push_back({a, mem(a)});
  endtask
  task automatic wait_over(input string name);
    int n;
    n = 0;
    while (!IF_over && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!IF_over) begin
      errors++;
      $display("FAIL %s_timeout IF_over=%b expected 1 within 20 cycles", name, IF_over);
    end
  endtask
  task automatic test_reset;
    @(negedge clk);
    resetn = 0;
    nf_tie = 0;
    nf_drv = 0;
    cancel = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({inst_req, IF_over, IF_inst, IF_pc} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state req=%b over=%b inst=%h pc=%h expected all 0", inst_req, IF_over, IF_inst, IF_pc);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (fetch_cnt !== 0 || drop_cnt !== 0) begin
      errors++;
      $display("FAIL reset_cnt fetch=%0d drop=%0d expected 0 0", fetch_cnt, drop_cnt);
    end
`endif
  endtask
  task automatic test_zero_wait;
    test_reset();
    lat = 0;
    push(32'h0);
    push(32'h4);
    push(32'h8);
    resetn = 1;
    nf_tie = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (k % 2 == 1) begin
        if (inst_req !== 1 || inst_addr !== 32'((k - 1) * 2) || IF_over !== 0) begin
          errors++;
          $display("FAIL zw_req k=%0d req=%b addr=%h over=%b expected 1 %h 0", k, inst_req, inst_addr, IF_over, 32'((k - 1) * 2));
        end
      end else if (inst_req !== 0 || IF_over !== 1) begin
        errors++;
        $display("FAIL zw_hold k=%0d req=%b over=%b expected 0 1", k, inst_req, IF_over);
      end
    end
    nf_tie = 0;
  endtask
  task automatic test_latency;
    test_reset();
    lat = 3;
    push(32'h0);
    resetn = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (k <= 4 && (inst_req !== 1 || inst_addr !== 0 || inst_ack !== (k == 4) || IF_over !== 0)) begin
        errors++;
        $display("FAIL lat_wait k=%0d req=%b addr=%h ack=%b over=%b expected 1 0 %b 0", k, inst_req, inst_addr, inst_ack, IF_over, k == 4);
      end
      if (k == 5 && (IF_over !== 1 || IF_inst !== 32'h2401_0005 || IF_pc !== 0)) begin
        errors++;
        $display("FAIL lat_hold over=%b inst=%h pc=%h expected 1 24010005 0", IF_over, IF_inst, IF_pc);
      end
    end
  endtask
  task automatic test_cancel_before_ack;
    push(32'h4);
    nf_drv = 1;
    @(negedge clk);
    nf_drv = 0;
    wait_over("cba_pc4");
    nf_drv = 1;
    @(negedge clk);
    nf_drv = 0;
    checks++;
    if (inst_req !== 1 || inst_addr !== 32'h8) begin
      errors++;
      $display("FAIL cba_req8 req=%b addr=%h expected 1 8", inst_req, inst_addr);
    end
    repeat (2) @(negedge clk);
    cancel = 1;
    cancel_target = 32'h100;
    @(negedge clk);
    cancel = 0;
    checks++;
    if (inst_addr !== 32'h8 || inst_ack !== 1) begin
      errors++;
      $display("FAIL cba_keep addr=%h ack=%b expected 8 1", inst_addr, inst_ack);
    end
    @(negedge clk);
    checks++;
    if (inst_req !== 1 || inst_addr !== 32'h100 || IF_over !== 0) begin
      errors++;
      $display("FAIL cba_redir req=%b addr=%h over=%b expected 1 100 0", inst_req, inst_addr, IF_over);
    end
    push(32'h100);
    wait_over("cba_pc100");
  endtask
  task automatic test_cancel_with_ack;
    nf_drv = 1;
    @(negedge clk);
    nf_drv = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (inst_addr !== 32'h104 || inst_ack !== 1) begin
      errors++;
      $display("FAIL cwa_ack addr=%h ack=%b expected 104 1", inst_addr, inst_ack);
    end
    cancel = 1;
    cancel_target = 32'h200;
    @(negedge clk);
    checks++;
    if (inst_req !== 1 || inst_addr !== 32'h200 || IF_over !== 0) begin
      errors++;
      $display("FAIL cwa_redir req=%b addr=%h over=%b expected 1 200 0", inst_req, inst_addr, IF_over);
    end
    cancel_target = 32'h250;
    @(negedge clk);
    cancel_target = 32'h303;
    @(negedge clk);
    cancel = 0;
    checks++;
    if (inst_addr !== 32'h200) begin
      errors++;
      $display("FAIL cwa_stable addr=%h expected 200", inst_addr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (inst_req !== 1 || inst_addr !== 32'h300 || IF_over !== 0) begin
      errors++;
      $display("FAIL cwa_latest req=%b addr=%h over=%b expected 1 300 0", inst_req, inst_addr, IF_over);
    end
    push(32'h300);
    wait_over("cwa_pc300");
  endtask
  task automatic test_hold;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (IF_over !== 1 || inst_req !== 0 || IF_pc !== 32'h300 || IF_inst !== mem(32'h300)) begin
        errors++;
        $display("FAIL hold k=%0d over=%b req=%b pc=%h inst=%h expected 1 0 300 %h", k, IF_over, inst_req, IF_pc, IF_inst, mem(32'h300));
      end
    end
    cancel = 1;
    cancel_target = 32'h40;
    nf_drv = 1;
    push(32'h40);
    @(negedge clk);
    cancel = 0;
    nf_drv = 0;
    checks++;
    if (inst_req !== 1 || inst_addr !== 32'h40 || IF_over !== 0) begin
      errors++;
      $display("FAIL hold_redir req=%b addr=%h over=%b expected 1 40 0", inst_req, inst_addr, IF_over);
    end
    wait_over("hold_pc40");
  endtask
  task automatic test_wrap;
    cancel = 1;
    cancel_target = 32'hFFFF_FFFC;
    nf_drv = 1;
    push(32'hFFFF_FFFC);
    @(negedge clk);
    cancel = 0;
    nf_drv = 0;
    wait_over("wrap_top");
    nf_drv = 1;
    push(32'h0);
    @(negedge clk);
    nf_drv = 0;
    checks++;
    if (inst_req !== 1 || inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr req=%b addr=%h expected 1 0", inst_req, inst_addr);
    end
    wait_over("wrap_zero");
  endtask
  task automatic test_reset_mid_req;
    nf_drv = 1;
    @(negedge clk);
    nf_drv = 0;
    checks++;
    if (inst_req !== 1 || inst_addr !== 32'h4) begin
      errors++;
      $display("FAIL rmr_req req=%b addr=%h expected 1 4", inst_req, inst_addr);
    end
    test_reset();
    lat = 0;
    push(32'h0);
    resetn = 1;
    @(negedge clk);
    checks++;
    if (inst_req !== 1 || inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL rmr_restart req=%b addr=%h expected 1 0", inst_req, inst_addr);
    end
    wait_over("rmr_pc0");
  endtask
  initial begin
    test_zero_wait();
    test_latency();
    test_cancel_before_ack();
    test_cancel_with_ack();
    test_hold();
    test_wrap();
    test_reset_mid_req();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_leftover entries=%0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
